// File: rtl/branch_recovery.sv
// branch_recovery: redirects fetch on branch resolution and walks squashed ROB tags youngest-to-oldest after a mispredict.
module branch_recovery #(
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fu_b_done,
  input  logic             jalr_bne_signal,
  input  logic             b_mispredict,
  input  logic [TAG_W-1:0] b_mispredict_tag,
  input  logic [31:0]      b_pc,
  input  logic [TAG_W-1:0] rob_fu_b,
  input  logic [TAG_W-1:0] rob_tail,
  input  logic             rollback_ready,
  output logic             recovery_ready,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             mispredict,
  output logic [TAG_W-1:0] mispredict_tag,
  output logic             rollback_valid,
  output logic [TAG_W-1:0] rollback_tag,
  output logic             flush_stall
);
  typedef enum logic [1:0] {IDLE, FLUSH, WALK, DONE} state_t;
  state_t state, state_n;
  logic [TAG_W-1:0] walk_ptr, walk_n, stop_p1;
  logic jalr_q, jalr_n, accept, last;
  function automatic logic [TAG_W-1:0] dec(input logic [TAG_W-1:0] t);
    return t == '0 ? TAG_W'(ROB_DEPTH - 1) : t - TAG_W'(1);
  endfunction
  // mispredict_tag doubles as the walk stop point; it only changes on acceptance
  assign stop_p1 = mispredict_tag == TAG_W'(ROB_DEPTH - 1) ? '0 : mispredict_tag + TAG_W'(1);
  assign accept = state == IDLE && fu_b_done;
  assign last = walk_ptr == stop_p1;
  always_comb begin
    state_n = state;
    walk_n = walk_ptr;
    jalr_n = accept && jalr_bne_signal && !b_mispredict;
    case (state)
      IDLE: if (accept && b_mispredict) begin
        state_n = FLUSH;
        walk_n = dec(rob_tail);
      end
      FLUSH: state_n = walk_ptr == mispredict_tag ? DONE : WALK;
      WALK: if (rollback_ready) begin
        state_n = last ? DONE : WALK;
        walk_n = last ? walk_ptr : dec(walk_ptr);
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      walk_ptr <= '0;
      jalr_q <= 1'b0;
      redirect_pc <= '0;
      mispredict_tag <= '0;
    end else begin
      state <= state_n;
      walk_ptr <= walk_n;
      jalr_q <= jalr_n;
      if (accept && (b_mispredict || jalr_bne_signal)) redirect_pc <= b_pc;
      if (accept && b_mispredict) mispredict_tag <= b_mispredict_tag;
    end
  end
  assign recovery_ready = state == IDLE;
  assign redirect_valid = state == FLUSH || jalr_q;
  assign mispredict = state == FLUSH;
  assign rollback_valid = state == WALK;
  assign rollback_tag = walk_ptr;
  assign flush_stall = state != IDLE;
  logic unused;
  assign unused = ^rob_fu_b;
endmodule

// File: doc/branch_recovery.md
# branch_recovery

Consumer of branch functional-unit results. Accepts each resolved branch/jump, redirects fetch for taken `bne` mispredicts and `jalr` targets, and broadcasts the mispredict tag to ROB/RS/FUs. It then walks the squashed ROB entries youngest-to-oldest so rename can restore map-table and free-list state. While recovery is in progress it stalls dispatch and new branch issue.

## Interface

Parameters:
- ROB_DEPTH, 16, ROB entries; tags wrap modulo ROB_DEPTH.
- TAG_W, 5, ROB tag width. The MSB is always 0 at depth 16.

Ports:
- clk  in  1  clock. Single clock domain.
- reset  in  1  synchronous, active-high reset.
- fu_b_done  in  1  branch result valid this cycle.
- jalr_bne_signal  in  1  result requires redirect: jalr, or taken bne.
- b_mispredict  in  1  taken bne; flush required.
- b_mispredict_tag  in  TAG_W  ROB tag of the mispredicted branch.
- b_pc  in  32  redirect target.
- rob_fu_b  in  TAG_W  ROB tag of the resolving branch.
- rob_tail  in  TAG_W  next ROB tag to allocate (current tail).
- rollback_ready  in  1  rename accepts one rollback entry.
- recovery_ready  out  1  high only in IDLE; branch issue must stall when low.
- redirect_valid  out  1  one-cycle fetch redirect pulse.
- redirect_pc  out  32  fetch target; valid with redirect_valid.
- mispredict  out  1  one-cycle flush broadcast.
- mispredict_tag  out  TAG_W  tag broadcast with mispredict.
- rollback_valid  out  1  rollback_tag is valid.
- rollback_tag  out  TAG_W  squashed ROB entry to undo.
- flush_stall  out  1  dispatch stall.

## Operation

States: IDLE, FLUSH, WALK, DONE.

- IDLE: result sampled when fu_b_done=1.
  - b_mispredict=1: capture redirect_pc=b_pc and mispredict_tag=b_mispredict_tag. Set walk_ptr=(rob_tail−1) mod 16 and stop=b_mispredict_tag. Go to FLUSH.
  - jalr_bne_signal=1 and b_mispredict=0 (jalr): next cycle redirect_valid=1 and redirect_pc=b_pc. Stay in IDLE; no flush, no walk.
  - Otherwise (not-taken bne): no action.
- FLUSH, one cycle: redirect_valid=1, mispredict=1, flush_stall=1.
  - If walk_ptr==stop (no younger entries), go to DONE.
  - Else go to WALK.
- WALK: rollback_valid=1, rollback_tag=walk_ptr, flush_stall=1.
  - On rollback_ready=1: if walk_ptr==(stop+1) mod 16, go to DONE. Else walk_ptr=(walk_ptr−1) mod 16.
  - On rollback_ready=0: hold walk_ptr and all outputs.
- DONE, one cycle: flush_stall=1, then go to IDLE.
- Tag arithmetic is modulo ROB_DEPTH: 0−1→15, 15+1→0. rob_tail is sampled only in IDLE at acceptance.
- fu_b_done outside IDLE is a protocol violation. The result is ignored and state is unchanged.
- Reset values: all outputs 0 except recovery_ready=1. State=IDLE, walk_ptr=0.

## Timing

- All outputs are registered. Mispredict accepted at edge N gives FLUSH outputs in cycle N+1 and the first rollback in cycle N+2.
- One rollback entry per cycle while rollback_ready=1. For k squashed entries, flush_stall stays high for k+2 cycles (FLUSH + k WALK + DONE), assuming no backpressure.
- recovery_ready falls in cycle N+1 and returns high the cycle after DONE.
- A jalr redirect pulse appears in cycle N+1 for exactly one cycle.
- Reset asserted in any state: at the next edge go to IDLE, clear all pulses and rollback, and set recovery_ready=1.

## Test plan

- Basic mispredict: bne mispredict, tag=3, rob_tail=7, rollback_ready=1.
  - N+1: redirect_valid=1 and mispredict=1 with tag 3 and the captured pc.
  - rollback_tag=6, 5, 4 on N+2..N+4.
  - DONE at N+5; flush_stall drops and recovery_ready=1 at N+6.
- Wrap-around: tag=14, rob_tail=2 → rollback tags 1, 0, 15, then DONE.
- Empty walk: tag=6, rob_tail=7 → FLUSH at N+1, DONE at N+2, no rollback_valid.
- jalr: jalr_bne_signal=1, b_mispredict=0, b_pc=0x0000_0100.
  - redirect_valid=1 with pc 0x100 for one cycle.
  - mispredict=0, flush_stall=0, recovery_ready stays 1.
- Backpressure and protocol violation: during WALK with rollback_tag=5, hold rollback_ready=0 for 2 cycles.
  - rollback_tag must hold at 5.
  - An fu_b_done pulse injected in WALK must be ignored.
- Reset mid-WALK: all outputs return to reset values next cycle. A following bne mispredict recovers normally.
